// File: rtl/bmp_out_stream_buffer.sv
// Output stage behind the image-processing accelerator.
// Processed words are queued in a small FIFO and then held in one output
// register that faces the master port. The last word of a frame shows up as
// valid code 11. The next frame is held off until the current frame has been
// fully delivered. A one-cycle strobe then marks completion.
module bmp_out_stream_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  input  logic                  in_last,
  output logic                  in_rdy,
  input  logic                  mstr_rdy,
  output logic [DATA_WIDTH-1:0] mstr_data,
  output logic [1:0]            mstr_data_valid,
  output logic                  mstr_cmplt,
  output logic [CNT_W-1:0]      frame_words
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  started_q;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic [1:0]            outVld_q, outVld_d;
  logic                  cmplt_q, cmplt_d;
  logic [CNT_W-1:0]      frameWords_q, frameWords_d;

  logic                  accept;
  logic                  xfer;
  logic                  outLoad;
  logic                  pop;
  logic                  bypass;
  logic                  push;
  logic                  lastXfer;
  logic                  frameStart;
  logic [DATA_WIDTH:0]   headWord;

  // Handshake decode. The output register refills from the FIFO head first.
  // It takes the incoming word directly only when the FIFO is empty.
  always_comb begin
    in_rdy     = started_q && (count_q != FULL_CNT) && (state_q != DRAIN);
    accept     = in_vld && in_rdy;
    xfer       = (outVld_q != 2'b00) && mstr_rdy;
    outLoad    = (outVld_q == 2'b00) || xfer;
    pop        = outLoad && (count_q != '0);
    bypass     = outLoad && (count_q == '0) && accept;
    push       = accept && !bypass;
    lastXfer   = xfer && (outVld_q == 2'b11);
    frameStart = accept && ((state_q == IDLE) || (state_q == DONE));
    headWord   = mem_q[rdPtr_q];
  end

  // Next-state for the FIFO pointers, the occupancy, and the output register.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    outData_d = outData_q;
    outVld_d  = outVld_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (outLoad) begin
      if (pop) begin
        outData_d = headWord[DATA_WIDTH-1:0];
        outVld_d  = {headWord[DATA_WIDTH], 1'b1};
      end else if (bypass) begin
        outData_d = in_data;
        outVld_d  = {in_last, 1'b1};
      end else begin
        outVld_d  = 2'b00;
      end
    end
  end

  // Frame sequencing. DONE also admits the next frame's first word, so a
  // waiting frame loses no cycle.
  always_comb begin
    state_d = state_q;
    cmplt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (accept && in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (lastXfer) begin
          state_d = DONE;
          cmplt_d = 1'b1;
        end
      end
      DONE: begin
        if (accept) begin
          state_d = in_last ? DRAIN : STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The word counter restarts when a new frame begins. It saturates and
  // does not wrap.
  always_comb begin
    frameWords_d = frameWords_q;
    if (frameStart) begin
      frameWords_d = '0;
    end else if (xfer && (frameWords_q != {CNT_W{1'b1}})) begin
      frameWords_d = frameWords_q + 1'b1;
    end
  end

  // FIFO storage needs no reset. The pointers and the count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {in_last, in_data};
    end
  end

  // Control and output registers. Reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      started_q    <= 1'b0;
      outData_q    <= '0;
      outVld_q     <= 2'b00;
      cmplt_q      <= 1'b0;
      frameWords_q <= '0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      started_q    <= 1'b1;
      outData_q    <= outData_d;
      outVld_q     <= outVld_d;
      cmplt_q      <= cmplt_d;
      frameWords_q <= frameWords_d;
    end
  end

  assign mstr_data       = outData_q;
  assign mstr_data_valid = outVld_q;
  assign mstr_cmplt      = cmplt_q;
  assign frame_words     = frameWords_q;

endmodule

// File: tb/tb_bmp_out_stream_buffer.sv
// Directed bench for bmp_out_stream_buffer. Each frame scenario is driven by
// hand and checked against hand-computed values. An independent scoreboard
// watches every master transfer to confirm order, data and the last-word code.
module tb_bmp_out_stream_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_vld;
  logic        in_last;
  logic        in_rdy;
  logic        mstr_rdy;
  logic [31:0] mstr_data;
  logic [1:0]  mstr_data_valid;
  logic        mstr_cmplt;
  logic [15:0] frame_words;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  word_t expQ[$];
  word_t monWord;
  int    vecCount;
  int    errCount;
  int    cmpltCount;
  int    acc;
  int    c0;

  bmp_out_stream_buffer #(
    .DATA_WIDTH(32),
    .DEPTH(8),
    .ADDR_W(3),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_vld(in_vld),
    .in_last(in_last),
    .in_rdy(in_rdy),
    .mstr_rdy(mstr_rdy),
    .mstr_data(mstr_data),
    .mstr_data_valid(mstr_data_valid),
    .mstr_cmplt(mstr_cmplt),
    .frame_words(frame_words)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog that stops a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic last,
                               input logic [31:0] data, input logic rdy);
    in_vld   = vld;
    in_last  = last;
    in_data  = data;
    mstr_rdy = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCmplt();
    for (int k = 0; k < 30; k++) begin
      if (mstr_cmplt) break;
      tick();
    end
    checkOutput("cmpltSeen", mstr_cmplt, 1);
  endtask

  // Scoreboard sampled on the falling edge: it records the handshakes that
  // take effect on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
    end else begin
      if (mstr_cmplt) cmpltCount++;
      if ((mstr_data_valid != 2'b00) && mstr_rdy) begin
        checkOutput("sbNonEmpty", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          monWord = expQ.pop_front();
          checkOutput("sbData", mstr_data, monWord.data);
          checkOutput("sbValid", mstr_data_valid, {monWord.last, 1'b1});
        end
      end
      if (in_vld && in_rdy) begin
        monWord.last = in_last;
        monWord.data = in_data;
        expQ.push_back(monWord);
      end
    end
  end

  initial begin
    vecCount   = 0;
    errCount   = 0;
    cmpltCount = 0;
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0);

    // Reset values
    repeat (3) tick();
    checkOutput("rstRdy", in_rdy, 0);
    checkOutput("rstValid", mstr_data_valid, 0);
    checkOutput("rstData", mstr_data, 0);
    checkOutput("rstCmplt", mstr_cmplt, 0);
    checkOutput("rstWords", frame_words, 0);
    rst = 1'b0;
    checkOutput("rdyAtRelease", in_rdy, 0);
    tick();
    checkOutput("rdyAfterRelease", in_rdy, 1);

    // Single-word frame
    applyStimulus(1, 1, 32'hA5A5A5A5, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("singleData", mstr_data, 32'hA5A5A5A5);
    checkOutput("singleValid", mstr_data_valid, 2'b11);
    checkOutput("singleRdyDrain", in_rdy, 0);
    checkOutput("singleCmpltEarly", mstr_cmplt, 0);
    tick();
    checkOutput("singleCmplt", mstr_cmplt, 1);
    checkOutput("singleWords", frame_words, 1);
    checkOutput("singleValidEmpty", mstr_data_valid, 0);
    tick();
    checkOutput("singleCmpltOnce", mstr_cmplt, 0);
    checkOutput("singleRdyBack", in_rdy, 1);

    // Streaming 20-word frame at full rate
    c0 = cmpltCount;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, (i == 19), i, 1);
      checkOutput("streamRdy", in_rdy, 1);
      tick();
      checkOutput("streamData", mstr_data, i);
      checkOutput("streamValid", mstr_data_valid, (i == 19) ? 2'b11 : 2'b01);
    end
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("streamRdyDrain", in_rdy, 0);
    tick();
    checkOutput("streamCmplt", mstr_cmplt, 1);
    checkOutput("streamWords", frame_words, 20);
    tick();
    checkOutput("streamCmpltCount", cmpltCount - c0, 1);

    // Backpressure: capacity is DEPTH+1 words
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 0, 100 + acc, 0);
      if (in_rdy) acc++;
      tick();
    end
    checkOutput("bpAccepted", acc, 9);
    checkOutput("bpRdyLow", in_rdy, 0);
    checkOutput("bpHeadData", mstr_data, 100);
    checkOutput("bpHeadValid", mstr_data_valid, 2'b01);
    applyStimulus(0, 0, 32'h0, 1);
    repeat (9) tick();
    checkOutput("bpDrainedValid", mstr_data_valid, 0);
    checkOutput("bpDrainedWords", frame_words, 9);
    applyStimulus(1, 1, 200, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 1);
    waitCmplt();
    checkOutput("bpWords", frame_words, 10);
    tick();

    // Frame gating: frame B waits out frame A's drain
    applyStimulus(1, 0, 400, 1);
    tick();
    applyStimulus(1, 0, 401, 1);
    tick();
    applyStimulus(1, 1, 402, 1);
    tick();
    checkOutput("gateLastValid", mstr_data_valid, 2'b11);
    checkOutput("gateLastData", mstr_data, 402);
    applyStimulus(1, 0, 500, 1);
    checkOutput("gateRdyDrain", in_rdy, 0);
    tick();
    checkOutput("gateCmplt", mstr_cmplt, 1);
    checkOutput("gateWordsA", frame_words, 3);
    checkOutput("gateRdyDone", in_rdy, 1);
    checkOutput("gateEmpty", mstr_data_valid, 0);
    tick();
    checkOutput("gateWordsRestart", frame_words, 0);
    checkOutput("gateDataB", mstr_data, 500);
    checkOutput("gateValidB", mstr_data_valid, 2'b01);
    checkOutput("gateCmpltOff", mstr_cmplt, 0);
    applyStimulus(1, 1, 501, 1);
    tick();
    checkOutput("gateWordsB1", frame_words, 1);
    checkOutput("gateLastB", mstr_data_valid, 2'b11);
    applyStimulus(0, 0, 32'h0, 1);
    tick();
    checkOutput("gateCmpltB", mstr_cmplt, 1);
    checkOutput("gateWordsB", frame_words, 2);
    tick();

    // Full FIFO with a pop, then a simultaneous push and pop
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 0, 300 + acc, 0);
      if (in_rdy) acc++;
      tick();
    end
    checkOutput("fullAccepted", acc, 9);
    applyStimulus(1, 0, 309, 1);
    checkOutput("fullNoCombRdy", in_rdy, 0);
    tick();
    checkOutput("fullRdyNext", in_rdy, 1);
    checkOutput("fullData1", mstr_data, 301);
    tick();
    checkOutput("pushPopRdy", in_rdy, 1);
    checkOutput("pushPopData", mstr_data, 302);
    applyStimulus(1, 0, 310, 0);
    tick();
    checkOutput("refullRdy", in_rdy, 0);
    checkOutput("refullHold", mstr_data, 302);
    applyStimulus(0, 0, 32'h0, 1);
    repeat (3) tick();
    applyStimulus(1, 1, 311, 1);
    checkOutput("fullLastRdy", in_rdy, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 1);
    waitCmplt();
    checkOutput("fullWords", frame_words, 12);
    tick();

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 600 + i, 1);
      tick();
    end
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("midWords", frame_words, 4);
    checkOutput("midValid", mstr_data_valid, 2'b01);
    c0 = cmpltCount;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abortValid", mstr_data_valid, 0);
    checkOutput("abortData", mstr_data, 0);
    checkOutput("abortRdy", in_rdy, 0);
    checkOutput("abortWords", frame_words, 0);
    checkOutput("abortCmplt", mstr_cmplt, 0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("abortRdyRelease", in_rdy, 0);
    tick();
    checkOutput("abortRdyBack", in_rdy, 1);
    checkOutput("abortNoCmplt", cmpltCount - c0, 0);
    applyStimulus(1, 0, 700, 1);
    tick();
    applyStimulus(1, 1, 701, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 1);
    waitCmplt();
    checkOutput("afterAbortWords", frame_words, 2);
    tick();
    tick();

    checkOutput("sbDrained", expQ.size(), 0);
    checkOutput("totalCmplt", cmpltCount, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
